pwm_half_bridge: RTL and testbench

Downstream consumer of the clock divider output. Samples the divided clock (TICK_IN) in the CLK_IN domain and advances an edge-aligned PWM counter once per divided-clock rising edge. Drives complementary high-side and low-side gate signals for one BLDC motor phase half-bridge. Duty is double-buffered and applied only at period wrap.

---
 rtl/pwm_half_bridge.sv | 199 +++++++++++++++++++
 tb/tb_pwm_half_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_half_bridge.sv
// ----------------------------------------------------------------------------
// pwm_half_bridge
//
// Edge-aligned PWM generator for one BLDC half-bridge phase. A divided clock
// (TICK_IN) is sampled in the CLK_IN domain. Each rising edge of TICK_IN
// advances a WIDTH-bit period counter. Duty is double-buffered: DUTY_LD
// captures a pending value. That value becomes active only when the counter
// wraps. The high-side and low-side gate outputs are decoded from a
// registered state machine, so they can never both be asserted.
//
// Optional build macro:
//    PWM_DEADTIME_EN - when defined, DEAD CLK_IN cycles with both gates off
//                      are inserted on every HI<->LO hand-over. When the
//                      macro is undefined, DEAD is ignored.
//
// Parameters:
//    WIDTH       counter/duty width; PWM period = 2^WIDTH ticks
//    DEAD        dead time in CLK_IN cycles (1..255)
//
// Ports:
//    CLK_IN      system clock
//    RST_N       asynchronous active-low reset
//    EN          phase enable; low forces both gates off
//    TICK_IN     divided clock, synchronous to CLK_IN
//    DUTY_IN     requested duty in ticks
//    DUTY_LD     strobe: capture DUTY_IN into the pending register
//    DUTY_ACK    one-cycle pulse when the pending duty becomes active
//    PERIOD_END  one-cycle pulse after a counter wrap
//    PWM_HI      high-side gate, active high
//    PWM_LO      low-side gate, active high
// ----------------------------------------------------------------------------
module pwm_half_bridge #(
   parameter int WIDTH = 9,
   parameter int DEAD  = 4
) (
   input  logic             CLK_IN,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             TICK_IN,
   input  logic [WIDTH-1:0] DUTY_IN,
   input  logic             DUTY_LD,
   output logic             DUTY_ACK,
   output logic             PERIOD_END,
   output logic             PWM_HI,
   output logic             PWM_LO
);

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_DT_HI = 3'd1,
      S_HI    = 3'd2,
      S_DT_LO = 3'd3,
      S_LO    = 3'd4
   } state_t;

   logic             r_tick_q;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_duty_act;
   logic [WIDTH-1:0] r_duty_pend;
   logic             r_pend_flag;
   logic             r_period_end;
   logic             r_duty_ack;
   state_t           r_state;
   state_t           w_state_next;

   logic             w_step;
   logic             w_wrap;
   logic             w_raw;

   // One step per TICK_IN rising edge, however long TICK_IN stays high.
   assign w_step = TICK_IN & ~r_tick_q;
   assign w_wrap = w_step & EN & (r_cnt == {WIDTH{1'b1}});
   assign w_raw  = EN & (r_cnt < r_duty_act);

   // -------------------------------------------------------------------------
   // Tick edge detect, period counter and double-buffered duty
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         r_tick_q     <= 1'b0;
         r_cnt        <= '0;
         r_duty_act   <= '0;
         r_duty_pend  <= '0;
         r_pend_flag  <= 1'b0;
         r_period_end <= 1'b0;
         r_duty_ack   <= 1'b0;
      end else begin
         r_tick_q     <= TICK_IN;
         r_period_end <= w_wrap;
         r_duty_ack   <= w_wrap & r_pend_flag;

         if (!EN) begin
            r_cnt <= '0;
         end else if (w_step) begin
            r_cnt <= r_cnt + WIDTH'(1);
         end

         if (w_wrap && r_pend_flag) begin
            r_duty_act  <= r_duty_pend;
            r_pend_flag <= 1'b0;
         end

         // A load in the wrap cycle goes after the apply above. The old
         // pending value is used now. The new value stays pending for the
         // next wrap.
         if (DUTY_LD) begin
            r_duty_pend <= DUTY_IN;
            r_pend_flag <= 1'b1;
         end
      end
   end

`ifdef PWM_DEADTIME_EN
   // -------------------------------------------------------------------------
   // Gate FSM with dead band
   // -------------------------------------------------------------------------
   localparam logic [7:0] DT_LOAD = 8'(DEAD - 1);

   logic [7:0] r_dt_cnt;
   logic [7:0] w_dt_cnt_next;

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= S_OFF;
         r_dt_cnt <= '0;
      end else begin
         r_state  <= w_state_next;
         r_dt_cnt <= w_dt_cnt_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_dt_cnt_next = r_dt_cnt;
      if (!EN) begin
         w_state_next = S_OFF;
      end else begin
         case (r_state)
            S_OFF: begin
               w_state_next  = w_raw ? S_DT_HI : S_DT_LO;
               w_dt_cnt_next = DT_LOAD;
            end
            S_HI: begin
               if (!w_raw) begin
                  w_state_next  = S_DT_LO;
                  w_dt_cnt_next = DT_LOAD;
               end
            end
            S_LO: begin
               if (w_raw) begin
                  w_state_next  = S_DT_HI;
                  w_dt_cnt_next = DT_LOAD;
               end
            end
            // If demand reverts mid-band, the gate that was about to turn
            // on never did. Fall straight back to the other side.
            S_DT_HI: begin
               if (!w_raw)               w_state_next = S_LO;
               else if (r_dt_cnt == 8'd0) w_state_next = S_HI;
               else                      w_dt_cnt_next = r_dt_cnt - 8'd1;
            end
            S_DT_LO: begin
               if (w_raw)                w_state_next = S_HI;
               else if (r_dt_cnt == 8'd0) w_state_next = S_LO;
               else                      w_dt_cnt_next = r_dt_cnt - 8'd1;
            end
            default: w_state_next = S_OFF;
         endcase
      end
   end
`else
   // -------------------------------------------------------------------------
   // Gate FSM without dead band
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_OFF;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = S_OFF;
      if (EN) begin
         w_state_next = w_raw ? S_HI : S_LO;
      end
   end
`endif

   // Outputs decoded from the registered state only.
   always_comb begin
      PWM_HI     = (r_state == S_HI);
      PWM_LO     = (r_state == S_LO);
      PERIOD_END = r_period_end;
      DUTY_ACK   = r_duty_ack;
   end

endmodule

// File: tb/tb_pwm_half_bridge.sv
// ----------------------------------------------------------------------------
// tb_pwm_half_bridge
//
// Self-checking bench for pwm_half_bridge at WIDTH=4 and DEAD=3.
// TICK_IN is a free-running waveform: high for tick_h cycles, then low for
// tick_l cycles. At 2/2, each count lasts 4 cycles, so a period is 64 cycles.
// Expected gate on-times come from a duty table. When PWM_DEADTIME_EN is
// defined, every gate segment is shortened by the dead band.
// ----------------------------------------------------------------------------
module tb_pwm_half_bridge;

   localparam int W    = 4;
   localparam int DEAD = 3;
   localparam int PER  = 64;   // cycles per PWM period at 2/2 ticks
`ifdef PWM_DEADTIME_EN
   localparam int DT = DEAD;
`else
   localparam int DT = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         tick;
   logic [W-1:0] duty_in;
   logic         duty_ld;
   logic         ack;
   logic         pe;
   logic         hi;
   logic         lo;

   int  n_pass  = 0;
   int  n_total = 0;
   int  tick_h  = 2;
   int  tick_l  = 2;
   bit  tick_run = 1'b0;
   int  overlap_cnt = 0;

   typedef struct {
      logic [W-1:0] duty;
      int           exp_hi;   // high-side cycles per period, no dead band
      int           exp_lo;   // low-side cycles per period, no dead band
   } vec_t;

   vec_t vecs [6];

   pwm_half_bridge #(.WIDTH(W), .DEAD(DEAD)) dut (
      .CLK_IN     (clk),
      .RST_N      (rst_n),
      .EN         (en),
      .TICK_IN    (tick),
      .DUTY_IN    (duty_in),
      .DUTY_LD    (duty_ld),
      .DUTY_ACK   (ack),
      .PERIOD_END (pe),
      .PWM_HI     (hi),
      .PWM_LO     (lo)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (hi && lo) overlap_cnt++;
   end

   // Divided-clock source
   initial begin
      int ph;
      ph   = 0;
      tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_run) begin
            tick = (ph < tick_h);
            ph++;
            if (ph >= tick_h + tick_l) ph = 0;
         end else begin
            tick = 1'b0;
            ph   = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Advance to the next negedge where PERIOD_END is seen. Also count any
   // DUTY_ACK seen before it.
   task automatic wait_pe(output int early_ack);
      early_ack = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (pe) return;
         if (ack) early_ack++;
      end
      check("period_end_timeout", 0, 1);
   endtask

   // Sample PER cycles, starting with the current one. The task ends on the
   // negedge that follows the window.
   task automatic count_window(output int nh, output int nl,
                               output int na, output int np);
      nh = 0; nl = 0; na = 0; np = 0;
      for (int i = 0; i < PER; i++) begin
         nh += int'(hi);
         nl += int'(lo);
         na += int'(ack);
         np += int'(pe);
         @(negedge clk);
      end
   endtask

   task automatic load(input logic [W-1:0] d);
      duty_in = d;
      duty_ld = 1'b1;
      @(negedge clk);
      duty_ld = 1'b0;
   endtask

   initial begin
      int ea, h, l, a, p, n;
      bit seen;

      vecs[0] = '{duty: 4'd0,  exp_hi: 0,  exp_lo: 64};
      vecs[1] = '{duty: 4'd5,  exp_hi: 20, exp_lo: 44};
      vecs[2] = '{duty: 4'd15, exp_hi: 60, exp_lo: 4};
      vecs[3] = '{duty: 4'd1,  exp_hi: 4,  exp_lo: 60};
      vecs[4] = '{duty: 4'd8,  exp_hi: 32, exp_lo: 32};
      vecs[5] = '{duty: 4'd10, exp_hi: 40, exp_lo: 24};

      // ---- reset and idle ----
      rst_n = 1'b0; en = 1'b0; duty_ld = 1'b0; duty_in = '0; tick_run = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_hi", int'(hi), 0);
      check("rst_lo", int'(lo), 0);
      check("rst_ack", int'(ack), 0);
      check("rst_pe", int'(pe), 0);
      rst_n = 1'b1;
      count_window(h, l, a, p);
      check("idle_hi", h, 0);
      check("idle_lo", l, 0);
      check("idle_pe", p, 0);

      // ---- table-driven duty application ----
      en = 1'b1;
      wait_pe(ea);
      for (int v = 0; v < 6; v++) begin
         repeat (10) @(negedge clk);
         load(vecs[v].duty);
         wait_pe(ea);
         check($sformatf("v%0d_early_ack", v), ea, 0);
         check($sformatf("v%0d_ack_at_wrap", v), int'(ack), 1);
         count_window(h, l, a, p);
         check($sformatf("v%0d_ack_once", v), a, 1);
         check($sformatf("v%0d_pe_once", v), p, 1);
         count_window(h, l, a, p);
         check($sformatf("v%0d_hi_cycles", v), h,
               (vecs[v].duty == 0) ? 0 : vecs[v].exp_hi - DT);
         check($sformatf("v%0d_lo_cycles", v), l,
               (vecs[v].duty == 0) ? PER : vecs[v].exp_lo - DT);
         check($sformatf("v%0d_no_ack", v), a, 0);
      end

      // ---- DUTY_LD in the wrap cycle (we are at a PERIOD_END negedge) ----
      repeat (5) @(negedge clk);
      load(4'd3);
      repeat (57) @(negedge clk);   // now one cycle before the wrap edge
      duty_in = 4'd12;
      duty_ld = 1'b1;
      @(negedge clk);
      duty_ld = 1'b0;
      check("wrapld_pe", int'(pe), 1);
      check("wrapld_ack", int'(ack), 1);
      count_window(h, l, a, p);
      check("wrapld_old_hi", h, 12 - DT);
      check("wrapld_old_lo", l, 52 - DT);
      count_window(h, l, a, p);
      check("wrapld_new_ack", a, 1);
      check("wrapld_new_hi", h, 48 - DT);
      check("wrapld_new_lo", l, 16 - DT);

      // ---- HI -> LO hand-over gap ----
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (hi) seen = 1'b1; else @(negedge clk);
      end
      check("gap_hi_seen", int'(seen), 1);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (!hi) seen = 1'b1; else @(negedge clk);
      end
      check("gap_hi_fall", int'(seen), 1);
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (lo) seen = 1'b1;
         else begin
            if (!hi) n++;
            @(negedge clk);
         end
      end
      check("gap_lo_seen", int'(seen), 1);
      check("gap_cycles", n, DT);

      // ---- wide tick: 4 high / 4 low ----
      tick_h = 4; tick_l = 4;
      wait_pe(ea);
      wait_pe(ea);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         seen = 1'b0;
         for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (pe) seen = 1'b1;
         end
         check($sformatf("wide_interval%0d", k), n, 128);
      end
      tick_h = 2; tick_l = 2;
      wait_pe(ea);
      wait_pe(ea);

      // ---- random duties, gates must never overlap ----
      for (int k = 0; k < 10; k++) begin
         repeat (3) @(negedge clk);
         load(4'($urandom_range(0, 15)));
         wait_pe(ea);
      end
      check("no_overlap", overlap_cnt, 0);

      // ---- EN falls while HI ----
      load(4'd10);
      wait_pe(ea);
      wait_pe(ea);
      repeat (12) @(negedge clk);
      check("abort_hi_before", int'(hi), 1);
      en = 1'b0;
      @(negedge clk);
      check("abort_hi_after", int'(hi), 0);
      check("abort_lo_after", int'(lo), 0);
      count_window(h, l, a, p);
      check("disabled_gates", h + l, 0);
      check("disabled_pe", p, 0);
      en = 1'b1;
      wait_pe(ea);
      wait_pe(ea);

      // ---- reset pulse while LO ----
      repeat (50) @(negedge clk);
      check("rst_mid_lo_before", int'(lo), 1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_lo_async", int'(lo), 0);
      check("rst_mid_hi_async", int'(hi), 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (pe) seen = 1'b1;
      end
      check("rst_cnt_zero", int'(n >= 60 && n <= 68), 1);
      count_window(h, l, a, p);
      count_window(h, l, a, p);
      check("rst_duty_hi", h, 0);
      check("rst_duty_lo", l, PER);
      check("rst_duty_ack", a, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
